// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word and handshake state, plus the memory arbiter's
// FSM state and requester identifiers.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;

  // Bit 0 is the core index and bit 1 marks the instruction class.
  typedef enum logic [2:0] {
    REQ_D0,
    REQ_D1,
    REQ_I0,
    REQ_I1,
    REQ_NONE
  } req_id_t;

  // ERROR ends an access just like ACCESS; only the load data is undefined.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two cores' caches, the arbiter and the RAM.
// The master modport is the cores-plus-RAM side; the arbiter uses slave.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic [1:0]      iREN;
  word_t     [1:0] iaddr;
  logic [1:0]      dREN;
  logic [1:0]      dWEN;
  word_t     [1:0] daddr;
  word_t     [1:0] dstore;
  logic [1:0]      iwait;
  logic [1:0]      dwait;
  word_t     [1:0] iload;
  word_t     [1:0] dload;

  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  word_t           ramload;
  ramstate_t       ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// pointer names the winning core. Grant is one-hot, or zero with no request.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the I and D caches of two cores: data beats
// instruction, round-robin between cores within a class. Defining
// ARB_STATS_EN adds saturating per-requester grant counters on grant_cnt.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int RR_INIT = 0
`ifdef ARB_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic CLK,
  input  logic RST,
  mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  , output logic [3:0][STAT_W-1:0] grant_cnt
`endif
);

  arb_state_t state, state_nxt;
  req_id_t    grant, grant_nxt;
  logic       d_ptr, d_ptr_nxt;
  logic       i_ptr, i_ptr_nxt;

  logic [1:0] d_req;
  logic [1:0] d_gnt;
  logic [1:0] i_gnt;
  logic       gcore;
  logic       active;
  logic       done;

  assign d_req = bus.dREN | bus.dWEN;
  assign gcore = grant[0];

  rr_pick2 u_pick_d (.req(d_req),    .ptr(d_ptr), .gnt(d_gnt));
  rr_pick2 u_pick_i (.req(bus.iREN), .ptr(i_ptr), .gnt(i_gnt));

  // The granted requester must still be asking; dropping it aborts the transfer.
  always_comb begin
    active = 1'b0;
    if (state == XFER) begin
      case (grant)
        REQ_D0, REQ_D1: active = d_req[gcore];
        REQ_I0, REQ_I1: active = bus.iREN[gcore];
        default:        active = 1'b0;
      endcase
    end
  end

  assign done = active & ram_done(bus.ramstate);

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (active) begin
      if (grant[1]) begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[gcore];
      end else begin
        bus.ramWEN   = bus.dWEN[gcore];
        bus.ramREN   = bus.dREN[gcore] & ~bus.dWEN[gcore];
        bus.ramaddr  = bus.daddr[gcore];
        bus.ramstore = bus.dstore[gcore];
      end
    end
  end

  always_comb begin
    bus.iwait = bus.iREN;
    bus.dwait = d_req;
    if (done) begin
      if (grant[1]) bus.iwait[gcore] = 1'b0;
      else          bus.dwait[gcore] = 1'b0;
    end
  end

  assign bus.iload = {2{bus.ramload}};
  assign bus.dload = {2{bus.ramload}};

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    d_ptr_nxt = d_ptr;
    i_ptr_nxt = i_ptr;
    case (state)
      IDLE: begin
        grant_nxt = REQ_NONE;
        if (|d_req) begin
          grant_nxt = d_gnt[0] ? REQ_D0 : (d_gnt[1] ? REQ_D1 : REQ_NONE);
          state_nxt = XFER;
        end else if (|bus.iREN) begin
          grant_nxt = i_gnt[0] ? REQ_I0 : (i_gnt[1] ? REQ_I1 : REQ_NONE);
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (!active) begin
          state_nxt = IDLE;
          grant_nxt = REQ_NONE;
        end else if (done) begin
          state_nxt = IDLE;
          grant_nxt = REQ_NONE;
          if (grant[1]) i_ptr_nxt = ~gcore;
          else          d_ptr_nxt = ~gcore;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = REQ_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state <= IDLE;
      grant <= REQ_NONE;
      d_ptr <= RR_INIT[0];
      i_ptr <= RR_INIT[0];
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      d_ptr <= d_ptr_nxt;
      i_ptr <= i_ptr_nxt;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_cnt <= '0;
    end else if (done && (grant_cnt[grant[1:0]] != '1)) begin
      grant_cnt[grant[1:0]] <= grant_cnt[grant[1:0]] + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model predicts the RAM
// and wait outputs every cycle, and literal expectations pin the key scenarios.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int RR_INIT = 0;

  logic CLK = 1'b0;
  logic RST;
  logic run_cmp = 1'b0;

  mem_arbiter_if bus ();

`ifdef ARB_STATS_EN
  logic [3:0][1:0] grant_cnt;
`endif

  mem_arbiter #(
    .RR_INIT(RR_INIT)
`ifdef ARB_STATS_EN
    , .STAT_W(2)
`endif
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: srv is the requester being served (0..3 = D0,D1,I0,I1), -1 when none.
  int srv   = -1;
  int ptr_d = RR_INIT;
  int ptr_i = RR_INIT;

  function automatic int pick(input logic [1:0] r, input int ptr);
    if (r == 2'b11) return ptr;
    if (r[0])       return 0;
    if (r[1])       return 1;
    return -1;
  endfunction

  function automatic logic m_active(input int s);
    if (s < 0) return 1'b0;
    if (s < 2) return bus.dREN[s] | bus.dWEN[s];
    return bus.iREN[s-2];
  endfunction

  function automatic logic m_done(input int s);
    return m_active(s) && (bus.ramstate == ACCESS || bus.ramstate == ERROR);
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      srv   <= -1;
      ptr_d <= RR_INIT;
      ptr_i <= RR_INIT;
    end else if (srv < 0) begin
      if ((bus.dREN | bus.dWEN) != 2'b00) srv <= pick(bus.dREN | bus.dWEN, ptr_d);
      else if (bus.iREN != 2'b00)         srv <= 2 + pick(bus.iREN, ptr_i);
    end else if (!m_active(srv)) begin
      srv <= -1;
    end else if (m_done(srv)) begin
      if (srv < 2) ptr_d <= 1 - srv;
      else         ptr_i <= 3 - srv;
      srv <= -1;
    end
  end

  always @(negedge CLK) begin : cmp
    logic       a;
    logic       dn;
    int         c;
    logic       ren;
    logic       wen;
    word_t      addr;
    word_t      st;
    logic [1:0] iw;
    logic [1:0] dw;
    if (!RST && run_cmp) begin
      a = m_active(srv);
      c = (srv < 0) ? 0 : srv % 2;
      ren = 1'b0; wen = 1'b0; addr = '0; st = '0;
      if (a && srv < 2) begin
        wen  = bus.dWEN[c];
        ren  = bus.dREN[c] & ~bus.dWEN[c];
        addr = bus.daddr[c];
        st   = bus.dstore[c];
      end else if (a) begin
        ren  = 1'b1;
        addr = bus.iaddr[c];
      end
      dn = m_done(srv);
      iw = bus.iREN;
      dw = bus.dREN | bus.dWEN;
      if (dn && srv < 2) dw[c] = 1'b0;
      if (dn && srv >= 2) iw[c] = 1'b0;
      check("m_ramREN", bus.ramREN, ren);
      check("m_ramWEN", bus.ramWEN, wen);
      if (ren | wen) begin
        check("m_ramaddr", bus.ramaddr, addr);
        check("m_ramstore", bus.ramstore, st);
      end
      check("m_iwait", bus.iwait, iw);
      check("m_dwait", bus.dwait, dw);
      check("m_iload0", bus.iload[0], bus.ramload);
      check("m_dload1", bus.dload[1], bus.ramload);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    clr();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    do_reset();
    run_cmp = 1'b1;

    // Reset state
    @(negedge CLK);
    check("rst_ramREN", bus.ramREN, 1'b0);
    check("rst_ramWEN", bus.ramWEN, 1'b0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    check("rst_ramstore", bus.ramstore, 32'h0);
    check("rst_waits", {bus.iwait, bus.dwait}, 4'h0);

    // Single instruction read
    tick();
    bus.iREN = 2'b01; bus.iaddr[0] = 32'h40; bus.ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check("i_pending", bus.iwait, 2'b01);
    tick();
    @(negedge CLK);
    check("i_xfer_ren", bus.ramREN, 1'b1);
    check("i_xfer_addr", bus.ramaddr, 32'h40);
    check("i_busy_wait", bus.iwait, 2'b01);
    tick();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    check("i_done_wait", bus.iwait, 2'b00);
    check("i_load", bus.iload[0], 32'hDEADBEEF);
    tick();
    bus.ramstate = FREE;
    @(negedge CLK);
    check("i_wait_one_cycle", bus.iwait, 2'b01);

    // Data write beats instruction; dREN with dWEN is a write
    do_reset();
    bus.iREN = 2'b01; bus.iaddr[0] = 32'h40;
    bus.dREN = 2'b01; bus.dWEN = 2'b01; bus.daddr[0] = 32'h80; bus.dstore[0] = 32'h1234;
    bus.ramstate = ACCESS;
    tick();
    @(negedge CLK);
    check("dw_wen", bus.ramWEN, 1'b1);
    check("dw_ren", bus.ramREN, 1'b0);
    check("dw_addr", bus.ramaddr, 32'h80);
    check("dw_store", bus.ramstore, 32'h1234);
    check("dw_iwait", bus.iwait, 2'b01);
    tick();
    bus.dREN = 2'b00; bus.dWEN = 2'b00;
    @(negedge CLK);
    check("dw_gap_ren", bus.ramREN, 1'b0);
    check("dw_gap_iwait", bus.iwait, 2'b01);
    tick();
    @(negedge CLK);
    check("dw_then_i_addr", bus.ramaddr, 32'h40);
    check("dw_then_i_store", bus.ramstore, 32'h0);
    check("dw_then_i_wait", bus.iwait, 2'b00);

    // Both data requesters held: D0, D1, D0, D1 with IDLE gaps
    do_reset();
    bus.dREN = 2'b11; bus.daddr[0] = 32'h100; bus.daddr[1] = 32'h200;
    bus.ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge CLK);
      if (k % 2 == 0) begin
        check("rr_addr", bus.ramaddr, ((k / 2) % 2 == 1) ? 32'h200 : 32'h100);
        check("rr_dwait", bus.dwait, ((k / 2) % 2 == 1) ? 2'b01 : 2'b10);
      end else begin
        check("rr_gap_ren", bus.ramREN, 1'b0);
        check("rr_gap_dwait", bus.dwait, 2'b11);
      end
    end

    // RAM busy for 10 cycles, then ACCESS; then an ERROR completion
    do_reset();
    bus.dREN = 2'b10; bus.daddr[1] = 32'h300; bus.ramstate = BUSY;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("busy_dwait", bus.dwait, 2'b10);
      check("busy_ren", bus.ramREN, 1'b1);
      check("busy_addr", bus.ramaddr, 32'h300);
      tick();
    end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    check("busy_done", bus.dwait, 2'b00);
    tick();
    bus.dREN = 2'b01; bus.daddr[0] = 32'h310; bus.ramstate = ERROR;
    tick();
    @(negedge CLK);
    check("err_release", bus.dwait, 2'b00);
    check("err_addr", bus.ramaddr, 32'h310);

    // Abort of D1, then the pending I1 is served
    do_reset();
    bus.dREN = 2'b10; bus.iREN = 2'b10;
    bus.daddr[1] = 32'h500; bus.iaddr[1] = 32'h600; bus.ramstate = BUSY;
    tick();
    @(negedge CLK);
    check("ab_xfer_ren", bus.ramREN, 1'b1);
    tick();
    bus.dREN = 2'b00;
    @(negedge CLK);
    check("ab_drop_ren", bus.ramREN, 1'b0);
    check("ab_iwait", bus.iwait, 2'b10);
    tick();
    @(negedge CLK);
    check("ab_idle_ren", bus.ramREN, 1'b0);
    tick();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    check("ab_i1_addr", bus.ramaddr, 32'h600);
    check("ab_i1_done", bus.iwait, 2'b00);

    // Abort of D0 leaves the data pointer on core 0
    do_reset();
    bus.dREN = 2'b01; bus.daddr[0] = 32'h700; bus.daddr[1] = 32'h800; bus.ramstate = BUSY;
    tick();
    tick();
    bus.dREN = 2'b00;
    tick();
    bus.dREN = 2'b11;
    tick();
    @(negedge CLK);
    check("ab_ptr_kept", bus.ramaddr, 32'h700);

`ifdef ARB_STATS_EN
    // Counters saturate at 3 with a 2-bit width
    do_reset();
    bus.dREN = 2'b01; bus.ramstate = ACCESS;
    for (int g = 1; g <= 4; g++) begin
      tick();
      tick();
      check("cnt_d0", grant_cnt[0], (g > 3) ? 2'd3 : 2'(g));
    end
    check("cnt_others", {grant_cnt[3], grant_cnt[2], grant_cnt[1]}, 6'h0);
`endif

    // Asynchronous reset in the middle of a write
    bus.dREN = 2'b00;
    bus.dWEN = 2'b01; bus.daddr[0] = 32'h900; bus.dstore[0] = 32'h55; bus.ramstate = BUSY;
    tick();
    tick();
    @(negedge CLK);
    check("rst_mid_wen_before", bus.ramWEN, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_wen", bus.ramWEN, 1'b0);
    check("rst_mid_ren", bus.ramREN, 1'b0);
`ifdef ARB_STATS_EN
    check("rst_mid_cnt", grant_cnt, 8'h0);
`endif
    clr();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_after_wen", bus.ramWEN, 1'b0);
    check("rst_after_dwait", bus.dwait, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction and data caches of two cores: four requesters D0, D1, I0, I1.
- Sits between the per-core cache/datapath request lines and the RAM.
- Produces the per-requester wait signals that each core's hazard unit turns into ihit/dhit stalls.
- Data requests have priority over instruction requests. Cores alternate round-robin within each class.

Parameters:
- RR_INIT, 0: core index that holds round-robin priority in both classes after reset.
- STAT_W, 32: width of each grant counter. Used only when ARB_STATS_EN is defined.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- iREN  in  2  instruction read request, bit c = core c
- iaddr  in  2x32  instruction address per core (word_t)
- dREN  in  2  data read request per core
- dWEN  in  2  data write request per core
- daddr  in  2x32  data address per core
- dstore  in  2x32  data write value per core
- iwait  out  2  instruction request pending, not yet served
- dwait  out  2  data request pending, not yet served
- iload  out  2x32  instruction read data per core
- dload  out  2x32  data read data per core
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- grant_cnt  out  4xSTAT_W  grants per requester. Present only with ARB_STATS_EN.

Behaviour:
- Reset: state IDLE, grant register NONE, both round-robin pointers = RR_INIT.
  - ramREN, ramWEN, ramaddr and ramstore all 0.
- FSM states:
  - IDLE
    - Samples requests. Chooses the winner if any dREN|dWEN is set, else if any iREN is set.
    - The class pointer picks the core when both cores request in that class.
    - Registers grant, goes to XFER next cycle.
    - Drives no RAM enables.
  - XFER
    - Drives the RAM from the granted requester's current inputs, combinationally.
    - Data grant: ramWEN = dWEN[c], ramREN = dREN[c] & ~dWEN[c]; ramaddr = daddr[c]; ramstore = dstore[c].
    - Instruction grant: ramREN = 1, ramaddr = iaddr[c], ramstore = 0.
    - ramstate == ACCESS: the granted wait output drops low in that same cycle. State goes to IDLE. The class pointer moves to the other core.
    - ramstate == ERROR: treated as ACCESS (load data is undefined). Requester is released.
    - FREE/BUSY: hold.
- Abort: if the granted requester deasserts its request while in XFER:
  - RAM enables drop in that cycle.
  - Next state is IDLE; pointer unchanged; no completion.
- Wait outputs (combinational):
  - iwait[c] = iREN[c] & ~(grant==Ic & state==XFER & ramstate==ACCESS|ERROR).
  - dwait[c] is the same with (dREN[c]|dWEN[c]) and grant Dc.
  - A non-requesting port always shows wait = 0.
- Load outputs: iload[c] and dload[c] carry ramload unconditionally. Valid only in the cycle the matching wait is low with the request high.
- Minimum latency: request sampled in IDLE at cycle N; grant at N+1; earliest completion in N+1 if RAM returns ACCESS immediately.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Simultaneous dREN & dWEN from one core: write wins.
- Starvation bound:
  - A data requester waits at most one other data grant.
  - Instruction requests starve only under continuous data traffic. This is accepted.
- Async RST mid-XFER: RAM enables drop immediately, FSM returns to IDLE; the in-flight access is abandoned.

Optional Feature:
- ARB_STATS_EN defined:
  - Four STAT_W grant counters, order D0, D1, I0, I1, exported on grant_cnt.
  - The winner's counter increments on every completed access (ACCESS or ERROR).
  - Counters saturate at all-ones and are cleared by RST.
- ARB_STATS_EN undefined: no counters, no grant_cnt port, no extra flops.

Decomposition:
- cpu_types_pkg holds:
  - word_t and ramstate_t (existing).
  - New arb_state_t enum {IDLE, XFER}.
  - New req_id_t enum {REQ_D0, REQ_D1, REQ_I0, REQ_I1, REQ_NONE}.
- Sub-module rr_pick2: two request bits plus pointer in, one-hot grant out. Instantiated once per class.

Test Plan:
- Reset, then iREN[0]=1, iaddr[0]=0x40, ramstate ACCESS one cycle after grant, ramload=0xDEADBEEF:
  - ramREN=1, ramaddr=0x40 during XFER.
  - iwait[0] low for exactly one cycle with iload[0]=0xDEADBEEF.
- iREN[0] and dWEN[0] together, daddr=0x80, dstore=0x1234:
  - Data served first: ramWEN=1, ramaddr=0x80, ramstore=0x1234.
  - Instruction served after an IDLE cycle; iwait[0] stays high until then.
- dREN[0] and dREN[1] held continuously, RR_INIT=0:
  - Grants alternate D0, D1, D0, D1.
  - No core served twice in a row while the other waits.
- ramstate held BUSY for 10 cycles, then ACCESS:
  - dwait stays high for 10 cycles; RAM outputs are stable the whole time.
  - Completion occurs in the ACCESS cycle.
- Granted dREN[1] dropped mid-XFER:
  - ramREN=0 that cycle, FSM back in IDLE, pointer unchanged.
  - A pending iREN[1] is then served.
- RST asserted mid-XFER:
  - ramREN/ramWEN=0 immediately, FSM IDLE.
  - With ARB_STATS_EN, grant_cnt all zero.
  - Saturation check: preload to max, then one more grant leaves the counter at max.
